// File: rtl/hazard_ctrl_pl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// State encoding, the hard-wired zero register index and parameter defaults.
package hazard_ctrl_pl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0]  REG_X0             = 5'd0;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_CNT_W          = 16;

endpackage : hazard_ctrl_pl_pkg

// File: rtl/hazard_ctrl_pl_lu_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a load in EX is about to write. Writes to x0 never cause a stall.
module hazard_lu_detect
    import hazard_ctrl_pl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    // Operand match against the load destination, qualified by operand use
    always_comb begin
        rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
        rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
        lu      = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
    end

endmodule : hazard_lu_detect

// File: rtl/hazard_ctrl_pl.sv
// Pipeline hazard/stall controller for the 5-stage core.
// Priority: memory wait (full freeze) > taken branch (flush) > load-use (bubble).
// Optional build macro HAZARD_STATS_EN adds saturating event counters as ports.
module hazard_ctrl_pl
    import hazard_ctrl_pl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
`endif
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    hz_state_e        state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    hazard_lu_detect u_lu (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu          (lu)
    );

    // Pipeline controls; a MEM_WAIT cycle without mem_busy behaves exactly as
    // RUN, so the outputs depend only on the current inputs
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Wait count for this cycle if memory is busy: first busy cycle counts as 1
    always_comb begin
        cnt_next = (state == ST_RUN) ? CNT_W'(1) : sat_inc(wait_cnt);
    end

    // Wait state, consecutive-wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (mem_busy) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= cnt_next;
            if (cnt_next >= TO_VAL) begin
                timeout_err <= 1'b1;
            end
        end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    // Event statistics: exactly one counter advances, following priority order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
            memwait_cnt  <= '0;
        end else if (mem_busy) begin
            memwait_cnt <= sat_inc(memwait_cnt);
        end else if (branch_taken) begin
            flush_cnt <= sat_inc(flush_cnt);
        end else if (lu) begin
            lu_stall_cnt <= sat_inc(lu_stall_cnt);
        end
    end
`endif

endmodule : hazard_ctrl_pl

// File: tb/tb_hazard_ctrl_pl.sv
// Self-checking bench for hazard_ctrl_pl (TIMEOUT_CYCLES=4).
// Outputs are compared every cycle against a behavioural model; directed
// steps pin the model with literal expected patterns.
module tb_hazard_ctrl_pl;

    localparam int unsigned T_OUT = 4;
    localparam int unsigned CW    = 16;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
    localparam logic [5:0] P_FRZ = 6'b000000;
    localparam logic [5:0] P_FLU = 6'b111111;
    localparam logic [5:0] P_BUB = 6'b000111;
    localparam logic [5:0] P_RUN = 6'b110101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, branch_taken, mem_busy;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, timeout_err;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] lu_stall_cnt, flush_cnt, memwait_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    int m_run;
    bit m_err;
    int m_lu, m_fl, m_mw;

    always #5 clk = ~clk;

    hazard_ctrl_pl #(.TIMEOUT_CYCLES(T_OUT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
`ifdef HAZARD_STATS_EN
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt),
        .memwait_cnt  (memwait_cnt),
`endif
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
    endfunction

    // ID instruction consumes a nonzero register that the EX load will write
    function automatic bit lu_m();
        bit reads;
        reads = 0;
        if (id_rs1_used && id_rs1 == ex_rd) reads = 1;
        if (id_rs2_used && id_rs2 == ex_rd) reads = 1;
        return ex_mem_read && (ex_rd != 5'd0) && reads;
    endfunction

    function automatic logic [5:0] exp_out();
        if (mem_busy)     return P_FRZ;
        if (branch_taken) return P_FLU;
        if (lu_m())       return P_BUB;
        return P_RUN;
    endfunction

    // model: length of the current run of busy cycles, sticky timeout, event tallies
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_err <= 1'b0; m_lu <= 0; m_fl <= 0; m_mw <= 0;
        end else if (mem_busy) begin
            m_run <= m_run + 1;
            if (m_run + 1 >= int'(T_OUT)) m_err <= 1'b1;
            m_mw <= m_mw + 1;
        end else begin
            m_run <= 0;
            if (branch_taken) m_fl <= m_fl + 1;
            else if (lu_m())  m_lu <= m_lu + 1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("outputs", 32'(outs()), 32'(exp_out()));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
`ifdef HAZARD_STATS_EN
            chk("lu_stall_cnt", 32'(lu_stall_cnt), 32'(m_lu));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_fl));
            chk("memwait_cnt", 32'(memwait_cnt), 32'(m_mw));
`endif
        end
    end

    task automatic drive(input bit busy, input bit br, input bit mr, input int rd,
                         input int rs1, input bit u1, input int rs2, input bit u2);
        @(posedge clk); #1;
        mem_busy = busy; branch_taken = br; ex_mem_read = mr; ex_rd = 5'(rd);
        id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    endtask

    task automatic pin_out(input string nm, input logic [5:0] exp);
        @(negedge clk); #1;
        chk(nm, 32'(outs()), 32'(exp));
    endtask

    task automatic pin_zero_after_reset(input string nm);
        chk({nm, "_err"}, 32'(timeout_err), 32'd0);
`ifdef HAZARD_STATS_EN
        chk({nm, "_stats"}, 32'(lu_stall_cnt | flush_cnt | memwait_cnt), 32'd0);
`endif
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        pin_zero_after_reset(nm);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_busy = 0; branch_taken = 0; ex_mem_read = 0; ex_rd = '0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        #2;
        pin_zero_after_reset("reset");
        chk("reset_outputs", 32'(outs()), 32'(P_RUN));
        #10 rst_n = 1'b1;
        chk_en = 1'b1;

        // load-use via rs1, then released
        drive(0, 0, 1, 5, 5, 1, 0, 0); pin_out("lu_rs1", P_BUB);
        drive(0, 0, 0, 5, 5, 1, 0, 0); pin_out("lu_release", P_RUN);
        // x0 and unused operand never stall; used rs2 does
        drive(0, 0, 1, 0, 0, 1, 0, 1); pin_out("lu_x0", P_RUN);
        drive(0, 0, 1, 7, 0, 0, 7, 0); pin_out("lu_rs2_unused", P_RUN);
        drive(0, 0, 1, 7, 0, 0, 7, 1); pin_out("lu_rs2", P_BUB);
        // branch beats load-use
        drive(0, 1, 1, 5, 5, 1, 0, 0); pin_out("br_over_lu", P_FLU);
        // memory wait with a pending branch
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0); pin_out("memwait_freeze", P_FRZ);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0); pin_out("memwait_exit_flush", P_FLU);
        chk("no_timeout_3", 32'(timeout_err), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); pin_out("after_wait_run", P_RUN);

        // timeout: the 4th consecutive busy edge sets the flag
        for (int i = 1; i <= 6; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk); #1;
            chk("timeout_ramp", 32'(timeout_err), (i > 4) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); pin_out("post_timeout_run", P_RUN);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        async_reset("clr");

        // reset in the middle of a wait returns to RUN with the count cleared
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        async_reset("midwait");
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); pin_out("midwait_run", P_RUN);
        chk("midwait_no_timeout", 32'(timeout_err), 32'd0);

        // randomized traffic with occasional async resets
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_ctrl_pl
